// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small word FIFO feeding a start/data/parity/stop
// serializer. Line settings are captured per frame when the word is popped.
module uart_tx_buffered #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          tx,
  input  logic [DIV_WIDTH-1:0]          baud_divider,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop_two
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]           count_reg;

  state_t                state_reg, state_next;
  logic [DIV_WIDTH-1:0]  baud_cnt_reg, baud_cnt_next;
  logic [DIV_WIDTH-1:0]  div_reg, div_next;
  logic [BW-1:0]         bit_idx_reg, bit_idx_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_odd_reg, par_odd_next;
  logic                  stop_two_reg, stop_two_next;
  logic                  second_stop_reg, second_stop_next;
  logic                  tx_reg, tx_next;
  logic                  push, pop, bit_end, frame_end;

  assign in_ready   = count_reg < DEPTH_C;
  assign push       = in_valid && in_ready;
  assign bit_end    = (baud_cnt_reg == div_reg);
  assign frame_end  = (state_reg == STOP) && bit_end && (second_stop_reg || !stop_two_reg);
  assign fifo_level = count_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);
  assign tx_done    = frame_end;
  assign tx         = tx_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  always_comb begin
    state_next       = state_reg;
    baud_cnt_next    = (state_reg == IDLE || bit_end) ? '0 : baud_cnt_reg + 1'b1;
    div_next         = div_reg;
    bit_idx_next     = bit_idx_reg;
    data_next        = data_reg;
    par_en_next      = par_en_reg;
    par_odd_next     = par_odd_reg;
    stop_two_next    = stop_two_reg;
    second_stop_next = second_stop_reg;
    tx_next          = tx_reg;
    pop              = 1'b0;

    case (state_reg)
      IDLE: begin
        if (count_reg != '0) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = data_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == LAST_BIT) begin
            if (par_en_reg) begin
              state_next = PARITY;
              tx_next    = (^data_reg) ^ par_odd_reg;
            end else begin
              state_next       = STOP;
              tx_next          = 1'b1;
              second_stop_next = 1'b0;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
            tx_next      = data_reg[bit_idx_next];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next       = STOP;
          tx_next          = 1'b1;
          second_stop_next = 1'b0;
        end
      end
      STOP: begin
        if (frame_end) begin
          if (count_reg != '0) pop = 1'b1;
          else                 state_next = IDLE;
        end else if (bit_end) begin
          second_stop_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // A pop starts a new frame and freezes the line settings for its duration.
    if (pop) begin
      state_next    = START;
      tx_next       = 1'b0;
      baud_cnt_next = '0;
      data_next     = mem[rd_ptr_reg];
      div_next      = baud_divider;
      par_en_next   = parity_en;
      par_odd_next  = parity_odd;
      stop_two_next = stop_two;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      baud_cnt_reg    <= '0;
      div_reg         <= '0;
      bit_idx_reg     <= '0;
      data_reg        <= '0;
      par_en_reg      <= 1'b0;
      par_odd_reg     <= 1'b0;
      stop_two_reg    <= 1'b0;
      second_stop_reg <= 1'b0;
      tx_reg          <= 1'b1;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      baud_cnt_reg    <= baud_cnt_next;
      div_reg         <= div_next;
      bit_idx_reg     <= bit_idx_next;
      data_reg        <= data_next;
      par_en_reg      <= par_en_next;
      par_odd_reg     <= par_odd_next;
      stop_two_reg    <= stop_two_next;
      second_stop_reg <= second_stop_next;
      tx_reg          <= tx_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a per-clock line model built from queued words,
// compared every cycle, plus directed frames with hand-derived waveforms.
module tb_uart_tx_buffered;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [2:0]      fifo_level;
  logic            busy;
  logic            tx_done;
  logic            tx;
  logic [DIVW-1:0] baud_divider;
  logic            parity_en;
  logic            parity_odd;
  logic            stop_two;

  uart_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fifo_level(fifo_level), .busy(busy), .tx_done(tx_done), .tx(tx),
    .baud_divider(baud_divider), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop_two(stop_two)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each queued frame is expanded into one slot per clock of line output.
  typedef struct packed {logic tx; logic done;} slot_t;
  slot_t         line_q[$];
  logic [DW-1:0] words_q[$];
  logic [DW-1:0] sent_log[$];

  task automatic build_frame(input logic [DW-1:0] w);
    int    per;
    int    nstop;
    logic  bits[$];
    slot_t s;
    per   = int'(baud_divider) + 1;
    nstop = stop_two ? 2 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (parity_en) bits.push_back((^w) ^ parity_odd);
    foreach (bits[b])
      for (int c = 0; c < per; c++) begin
        s.tx = bits[b]; s.done = 1'b0; line_q.push_back(s);
      end
    for (int c = 0; c < nstop * per; c++) begin
      s.tx = 1'b1; s.done = (c == nstop * per - 1); line_q.push_back(s);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q.delete();
      words_q.delete();
    end else begin
      logic          acc;
      logic [DW-1:0] w;
      acc = in_valid && (words_q.size() < DEPTH);
      if (line_q.size() != 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && words_q.size() != 0) begin
        w = words_q.pop_front();
        sent_log.push_back(w);
        build_frame(w);
      end
      if (acc) words_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    check("tx",         {63'd0, tx},         {63'd0, (line_q.size() != 0) ? line_q[0].tx : 1'b1});
    check("tx_done",    {63'd0, tx_done},    {63'd0, (line_q.size() != 0) ? line_q[0].done : 1'b0});
    check("busy",       {63'd0, busy},       {63'd0, (line_q.size() != 0) || (words_q.size() != 0)});
    check("fifo_level", {61'd0, fifo_level}, 64'(words_q.size()));
    check("in_ready",   {63'd0, in_ready},   {63'd0, words_q.size() < DEPTH});
  end

  logic [DW-1:0] pw [8];
  logic          cap [256];
  logic          dn  [256];
  int            cap_done;

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pw[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_low();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (tx === 1'b0) break;
    end
    check("start_seen", {63'd0, tx}, 64'd0);
  endtask

  task automatic capture(input int n, input bit chg);
    wait_low();
    cap_done = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      cap[k] = tx;
      dn[k]  = tx_done;
      if (tx_done) cap_done++;
      if (chg && k == 8) begin
        stop_two     = 1'b1;
        baud_divider = 16'd7;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int t = 0; t < limit; t++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    check("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [39:0] got40;
    int          idx0;
    int          bad;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    baud_divider = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; stop_two = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", {63'd0, tx}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_level", {61'd0, fifo_level}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_done", {63'd0, tx_done}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1, divider 3, 0xA5
    pw[0] = 8'hA5;
    fork push_seq(1); capture(40, 1'b0); join
    for (int k = 0; k < 40; k++) got40[39-k] = cap[k];
    check("a5_waveform", {24'd0, got40}, {24'd0, 40'b0000_1111_0000_1111_0000_0000_1111_0000_1111_1111});
    check("a5_done_count", 64'(cap_done), 64'd1);
    check("a5_done_last", {63'd0, dn[39]}, 64'd1);
    @(negedge clk);
    check("a5_busy_after", {63'd0, busy}, 64'd0);

    // 8O1 then 8E1, divider 1, 0x03: parity bit occupies samples 18..19
    baud_divider = 16'd1; parity_en = 1'b1; parity_odd = 1'b1;
    pw[0] = 8'h03;
    fork push_seq(1); capture(22, 1'b0); join
    check("odd_parity", {62'd0, cap[18], cap[19]}, 64'b11);
    check("odd_done", {63'd0, dn[21]}, 64'd1);
    wait_idle(50);
    parity_odd = 1'b0;
    fork push_seq(1); capture(22, 1'b0); join
    check("even_parity", {62'd0, cap[18], cap[19]}, 64'b00);
    wait_idle(50);

    // back-to-back frames, 8N1 divider 3
    baud_divider = 16'd3; parity_en = 1'b0;
    pw[0] = 8'h5A; pw[1] = 8'h00; pw[2] = 8'hFF;
    fork push_seq(3); capture(120, 1'b0); join
    check("b2b_done_count", 64'(cap_done), 64'd3);
    check("b2b_done_pos", {61'd0, dn[39], dn[79], dn[119]}, 64'b111);
    check("b2b_gap1", {56'd0, cap[36], cap[37], cap[38], cap[39], cap[40], cap[41], cap[42], cap[43]}, 64'hF0);
    check("b2b_gap2", {56'd0, cap[76], cap[77], cap[78], cap[79], cap[80], cap[81], cap[82], cap[83]}, 64'hF0);
    @(negedge clk);
    check("b2b_busy_after", {63'd0, busy}, 64'd0);

    // full FIFO, divider 15: first word pops on the second edge, so five are accepted
    baud_divider = 16'd15;
    pw[0] = 8'h11; pw[1] = 8'h22; pw[2] = 8'h33; pw[3] = 8'h44; pw[4] = 8'h55; pw[5] = 8'h66;
    idx0 = sent_log.size();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = pw[i];
      @(negedge clk);
      if (i == 4) begin
        check("full_level", {61'd0, fifo_level}, 64'd4);
        check("full_ready", {63'd0, in_ready}, 64'd0);
      end
    end
    in_valid = 1'b0;
    check("full_reject_level", {61'd0, fifo_level}, 64'd4);
    wait_idle(2000);
    check("full_sent_count", 64'(sent_log.size() - idx0), 64'd5);
    for (int i = 0; i < 5; i++)
      if (idx0 + i < sent_log.size())
        check("full_order", {56'd0, sent_log[idx0+i]}, {56'd0, pw[i]});

    // reset during DATA with two words queued
    baud_divider = 16'd3;
    pw[0] = 8'hA1; pw[1] = 8'hB2; pw[2] = 8'hC3;
    fork push_seq(3); wait_low(); join
    repeat (6) @(negedge clk);
    check("pre_rst_level", {61'd0, fifo_level}, 64'd2);
    #2;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    check("midrst_tx", {63'd0, tx}, 64'd1);
    check("midrst_level", {61'd0, fifo_level}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done !== 1'b0 || fifo_level !== 3'd0) bad++;
    end
    check("post_rst_silent", 64'(bad), 64'd0);

    // settings change mid-frame only affect the following frame
    baud_divider = 16'd3; stop_two = 1'b0;
    pw[0] = 8'h55; pw[1] = 8'h01;
    fork push_seq(2); capture(128, 1'b1); join
    check("cfg_done_count", 64'(cap_done), 64'd2);
    check("cfg_done_pos", {62'd0, dn[39], dn[127]}, 64'b11);
    check("cfg_frame1_stop", {60'd0, cap[35], cap[36], cap[39], cap[40]}, 64'b0110);
    check("cfg_frame2_start", {59'd0, cap[47], cap[48], cap[55], cap[56], cap[111]}, 64'b01100);
    check("cfg_frame2_stop", {62'd0, cap[112], cap[127]}, 64'b11);
    stop_two = 1'b0;
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
